// File: rtl/cpu_pkg.sv
// Shared CPU types: op classes driving flag capture and the {N,V,Z} flag
// struct exchanged with PC control.
package cpu_pkg;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_Z    = 2'd1,
      CLS_NVZ  = 2'd2
   } flg_cls_t;

   localparam int FLG_Z = 0;
   localparam int FLG_V = 1;
   localparam int FLG_N = 2;

   // Member order yields bit2=N, bit1=V, bit0=Z when packed.
   typedef struct packed {
      logic n;
      logic v;
      logic z;
   } flag_t;

endpackage

// File: rtl/flag_register_unit_if.sv
// Pipeline-side bundle of the flag register unit: EX results, ID issue
// tracking and the branch flag req/ack handshake.
interface flag_register_unit_if
   import cpu_pkg::*;
#(
   parameter int DW       = 16,
   parameter int MAX_INFL = 3
);
   localparam int CW = $clog2(MAX_INFL + 1);

   logic          id_issue;
   logic          id_sets_flg;
   logic          ex_valid;
   flg_cls_t      ex_cls;
   logic [DW-1:0] ex_result;
   logic          ex_ovfl;
   logic          stall;
   logic          flush;
   logic          br_req;
   logic          br_ack;
   flag_t         flags;
   logic [CW-1:0] infl_cnt;

   modport master (
      output id_issue, id_sets_flg, ex_valid, ex_cls, ex_result, ex_ovfl,
             stall, flush, br_req,
      input  br_ack, flags, infl_cnt
   );

   modport slave (
      input  id_issue, id_sets_flg, ex_valid, ex_cls, ex_result, ex_ovfl,
             stall, flush, br_req,
      output br_ack, flags, infl_cnt
   );

endinterface

// File: rtl/flag_register_unit_infl_counter.sv
// Saturating up/down counter of flag writers between ID issue and EX commit;
// clear has priority over inc/dec.
module flag_infl_counter #(
   parameter  int MAX_INFL = 3,
   localparam int CW       = $clog2(MAX_INFL + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc_i,
   input  logic          dec_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o
);

   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFL);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: default assignment first so no path through the block leaves cnt_d unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

   // More writers issued than can be tracked, or a commit with none tracked.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(inc_i && !dec_i && !clr_i && cnt_q == CNT_MAX));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(dec_i && !inc_i && !clr_i && cnt_q == '0));

endmodule

// File: rtl/flag_register_unit.sv
// Architectural {N,V,Z} flags captured from EX commits, plus the in-flight
// writer tracking that gates the branch flag handshake.
module flag_register_unit
   import cpu_pkg::*;
#(
   parameter  int DW       = 16,
   parameter  int MAX_INFL = 3,
   localparam int CW       = $clog2(MAX_INFL + 1)
) (
   input logic                  clk,
   input logic                  rst_n,
   flag_register_unit_if.slave  bus
);

   logic          commit;
   logic          wr_commit;
   logic          inc;
   logic [CW-1:0] cnt;
   flag_t         flags_q;
   flag_t         flags_d;

   assign commit    = bus.ex_valid & ~bus.stall & ~bus.flush;
   assign wr_commit = commit & (bus.ex_cls != CLS_NONE);
   assign inc       = bus.id_issue & bus.id_sets_flg & ~bus.flush;

   always_comb begin
      flags_d = flags_q;
      if (commit) begin
         unique case (bus.ex_cls)
            CLS_NVZ: begin
               flags_d.z = (bus.ex_result == '0);
               flags_d.v = bus.ex_ovfl;
               flags_d.n = bus.ex_result[DW-1];
            end
            CLS_Z:   flags_d.z = (bus.ex_result == '0);
            default: flags_d = flags_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   flag_infl_counter #(.MAX_INFL(MAX_INFL)) u_infl_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (inc),
      .dec_i (wr_commit),
      .clr_i (bus.flush),
      .cnt_o (cnt)
   );

   // Ack only once every older writer has landed; a writer committing now
   // would make the registered flags stale, so it blocks ack this cycle.
   assign bus.br_ack   = bus.br_req & (cnt == '0) & ~wr_commit;
   assign bus.flags    = flags_q;
   assign bus.infl_cnt = cnt;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit: flag capture per class, in-flight
// tracking, branch handshake, stall/flush and asynchronous reset.
module tb_flag_register_unit;
   import cpu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   flag_register_unit_if #(.DW(16), .MAX_INFL(3)) ifc ();

   flag_register_unit #(.DW(16), .MAX_INFL(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      ifc.id_issue    = 1'b0;
      ifc.id_sets_flg = 1'b0;
      ifc.ex_valid    = 1'b0;
      ifc.ex_cls      = CLS_NONE;
      ifc.ex_result   = 16'h0000;
      ifc.ex_ovfl     = 1'b0;
      ifc.stall       = 1'b0;
      ifc.flush       = 1'b0;
   endtask

   task automatic issue_writer();
      ifc.id_issue    = 1'b1;
      ifc.id_sets_flg = 1'b1;
   endtask

   task automatic drive_commit(input flg_cls_t cls, input logic [15:0] res, input logic ovfl);
      ifc.ex_valid  = 1'b1;
      ifc.ex_cls    = cls;
      ifc.ex_result = res;
      ifc.ex_ovfl   = ovfl;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      ifc.br_req = 1'b0;
      #3;
      n_cmp++; if (ifc.flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", ifc.flags); end
      n_cmp++; if (ifc.infl_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", ifc.infl_cnt); end
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ifc.br_ack); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_nvz_zero();
      issue_writer();
      step();
      n_cmp++; if (ifc.infl_cnt !== 2'd1) begin n_bad++; $display("FAIL nvz0_issue_cnt: got %0d want 1", ifc.infl_cnt); end
      drive_idle();
      drive_commit(CLS_NVZ, 16'h0000, 1'b0);
      step();
      drive_idle();
      n_cmp++; if (ifc.flags !== 3'b001) begin n_bad++; $display("FAIL nvz0_flags: got %b want 001", ifc.flags); end
      n_cmp++; if (ifc.infl_cnt !== 2'd0) begin n_bad++; $display("FAIL nvz0_cnt: got %0d want 0", ifc.infl_cnt); end
   endtask

   task automatic test_nvz_neg_then_z();
      issue_writer();
      step();
      drive_idle();
      drive_commit(CLS_NVZ, 16'h8000, 1'b1);
      step();
      drive_idle();
      n_cmp++; if (ifc.flags !== 3'b110) begin n_bad++; $display("FAIL nvz_neg_flags: got %b want 110", ifc.flags); end
      issue_writer();
      step();
      drive_idle();
      drive_commit(CLS_Z, 16'h0005, 1'b1);
      step();
      drive_idle();
      n_cmp++; if (ifc.flags !== 3'b110) begin n_bad++; $display("FAIL clsz_flags: got %b want 110", ifc.flags); end
      n_cmp++; if (ifc.infl_cnt !== 2'd0) begin n_bad++; $display("FAIL clsz_cnt: got %0d want 0", ifc.infl_cnt); end
   endtask

   task automatic test_handshake();
      issue_writer();
      step();
      drive_idle();
      n_cmp++; if (ifc.infl_cnt !== 2'd1) begin n_bad++; $display("FAIL hs_cnt_issue: got %0d want 1", ifc.infl_cnt); end
      ifc.br_req = 1'b1;
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_pending: got %b want 0", ifc.br_ack); end
      step();
      drive_commit(CLS_NVZ, 16'h7FFF, 1'b0);
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_commit_cycle: got %b want 0", ifc.br_ack); end
      step();
      drive_idle();
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b1) begin n_bad++; $display("FAIL hs_ack_after: got %b want 1", ifc.br_ack); end
      n_cmp++; if (ifc.flags !== 3'b000) begin n_bad++; $display("FAIL hs_flags: got %b want 000", ifc.flags); end
      ifc.br_req = 1'b0;
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_noreq: got %b want 0", ifc.br_ack); end
   endtask

   task automatic test_back_to_back();
      issue_writer();
      step();
      drive_idle();
      drive_commit(CLS_NVZ, 16'h0000, 1'b0);
      issue_writer();
      ifc.br_req = 1'b1;
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_commit: got %b want 0", ifc.br_ack); end
      step();
      drive_idle();
      #1;
      n_cmp++; if (ifc.infl_cnt !== 2'd1) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 1", ifc.infl_cnt); end
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_held: got %b want 0", ifc.br_ack); end
      n_cmp++; if (ifc.flags !== 3'b001) begin n_bad++; $display("FAIL b2b_flags1: got %b want 001", ifc.flags); end
      drive_commit(CLS_NVZ, 16'hFFFF, 1'b1);
      step();
      drive_idle();
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack_final: got %b want 1", ifc.br_ack); end
      n_cmp++; if (ifc.flags !== 3'b110) begin n_bad++; $display("FAIL b2b_flags2: got %b want 110", ifc.flags); end
      n_cmp++; if (ifc.infl_cnt !== 2'd0) begin n_bad++; $display("FAIL b2b_cnt_final: got %0d want 0", ifc.infl_cnt); end
      ifc.br_req = 1'b0;
   endtask

   task automatic test_stall_flush();
      issue_writer();
      step();
      step();
      drive_idle();
      n_cmp++; if (ifc.infl_cnt !== 2'd2) begin n_bad++; $display("FAIL sf_cnt_issue: got %0d want 2", ifc.infl_cnt); end
      drive_commit(CLS_NVZ, 16'h0000, 1'b0);
      ifc.stall  = 1'b1;
      ifc.br_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (ifc.flags !== 3'b110) begin n_bad++; $display("FAIL sf_stall_flags[%0d]: got %b want 110", i, ifc.flags); end
         n_cmp++; if (ifc.infl_cnt !== 2'd2) begin n_bad++; $display("FAIL sf_stall_cnt[%0d]: got %0d want 2", i, ifc.infl_cnt); end
         n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL sf_stall_ack[%0d]: got %b want 0", i, ifc.br_ack); end
      end
      ifc.stall = 1'b0;
      ifc.flush = 1'b1;
      #1;
      n_cmp++; if (ifc.br_ack !== 1'b0) begin n_bad++; $display("FAIL sf_ack_flush_cycle: got %b want 0", ifc.br_ack); end
      step();
      drive_idle();
      #1;
      n_cmp++; if (ifc.infl_cnt !== 2'd0) begin n_bad++; $display("FAIL sf_cnt_flushed: got %0d want 0", ifc.infl_cnt); end
      n_cmp++; if (ifc.flags !== 3'b110) begin n_bad++; $display("FAIL sf_flags_flushed: got %b want 110", ifc.flags); end
      n_cmp++; if (ifc.br_ack !== 1'b1) begin n_bad++; $display("FAIL sf_ack_after_flush: got %b want 1", ifc.br_ack); end
      ifc.br_req = 1'b0;
   endtask

   task automatic test_async_reset();
      issue_writer();
      step();
      drive_idle();
      drive_commit(CLS_NVZ, 16'h8000, 1'b1);
      issue_writer();
      step();
      drive_idle();
      drive_commit(CLS_Z, 16'h0000, 1'b0);
      issue_writer();
      step();
      drive_idle();
      issue_writer();
      step();
      drive_idle();
      n_cmp++; if (ifc.flags !== 3'b111) begin n_bad++; $display("FAIL ar_pre_flags: got %b want 111", ifc.flags); end
      n_cmp++; if (ifc.infl_cnt !== 2'd2) begin n_bad++; $display("FAIL ar_pre_cnt: got %0d want 2", ifc.infl_cnt); end
      ifc.br_req = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ifc.flags !== 3'b000) begin n_bad++; $display("FAIL ar_flags_async: got %b want 000", ifc.flags); end
      n_cmp++; if (ifc.infl_cnt !== 2'd0) begin n_bad++; $display("FAIL ar_cnt_async: got %0d want 0", ifc.infl_cnt); end
      #1;
      rst_n = 1'b1;
      step();
      n_cmp++; if (ifc.flags !== 3'b000) begin n_bad++; $display("FAIL ar_flags_post: got %b want 000", ifc.flags); end
      n_cmp++; if (ifc.br_ack !== 1'b1) begin n_bad++; $display("FAIL ar_ack_post: got %b want 1", ifc.br_ack); end
      ifc.br_req = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_nvz_zero();
      test_nvz_neg_then_z();
      test_handshake();
      test_back_to_back();
      test_stall_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
